// File: rtl/ysyx_23060096_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_23060096_ifu -- instruction fetch unit
//
// Owns the architectural PC and keeps at most one fetch outstanding to
// instruction memory. The returned word is handed to decode/execute under a
// valid/ready handshake. The next PC comes back from execute and is sampled
// on each hand-off.
//
// Ports
//   clk, rst          core clock, asynchronous active-high reset
//   imem_req_valid    fetch request valid (state decode only)
//   imem_req_ready    memory accepts the request
//   imem_addr         fetch address, always equal to pc
//   imem_rsp_valid    response valid (only looked at while waiting)
//   imem_rsp_data     fetched instruction word
//   imem_rsp_err      access error, qualified by imem_rsp_valid
//   inst_valid        inst/pc valid for downstream (state decode only)
//   inst_ready        downstream consumes the instruction
//   inst, pc          held instruction word and its address
//   npc, halt         next PC / ebreak, sampled on inst_valid && inst_ready
//   halted, fault     terminal stop indications
//   fault_cause       0 none, 1 memory error, 2 misaligned npc
//   fetch_cnt         instructions handed downstream (wraps)
// ----------------------------------------------------------------------------
module ysyx_23060096_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic [31:0] npc,
    input  logic        halt,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
        S_HALT  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [1:0]  CAUSE_NONE  = 2'd0;
    localparam logic [1:0]  CAUSE_MEM   = 2'd1;
    localparam logic [1:0]  CAUSE_ALIGN = 2'd2;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic [31:0] fetch_cnt_r;
    logic [1:0]  fault_cause_r;

    logic        handoff_s;
    logic        rsp_ok_s;
    logic        rsp_bad_s;
    logic        npc_misaligned_s;

    // Qualified events; responses only count while a fetch is outstanding.
    always_comb begin
        handoff_s        = (state_r == S_VALID) && inst_ready;
        rsp_ok_s         = (state_r == S_WAIT) && imem_rsp_valid && !imem_rsp_err;
        rsp_bad_s        = (state_r == S_WAIT) && imem_rsp_valid && imem_rsp_err;
        npc_misaligned_s = (npc[1:0] != 2'b00);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                state_next_s = S_REQ;
            end
            S_REQ: begin
                if (imem_req_ready) begin
                    state_next_s = S_WAIT;
                end else begin
                    state_next_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (rsp_bad_s) begin
                    state_next_s = S_FAULT;
                end else if (rsp_ok_s) begin
                    state_next_s = S_VALID;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_VALID: begin
                // halt wins over a misaligned npc
                if (!inst_ready) begin
                    state_next_s = S_VALID;
                end else if (halt) begin
                    state_next_s = S_HALT;
                end else if (npc_misaligned_s) begin
                    state_next_s = S_FAULT;
                end else begin
                    state_next_s = S_REQ;
                end
            end
            S_HALT: begin
                state_next_s = S_HALT;
            end
            S_FAULT: begin
                state_next_s = S_FAULT;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // PC, instruction buffer, hand-off counter and fault cause.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            inst_r        <= NOP_INST;
            fetch_cnt_r   <= 32'd0;
            fault_cause_r <= CAUSE_NONE;
        end else begin
            if (rsp_ok_s) begin
                inst_r <= imem_rsp_data;
            end
            if (rsp_bad_s) begin
                fault_cause_r <= CAUSE_MEM;
            end
            if (handoff_s) begin
                pc_r        <= npc;
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
                if (!halt && npc_misaligned_s) begin
                    fault_cause_r <= CAUSE_ALIGN;
                end
            end
        end
    end

    // Handshake and status outputs decode the state register only.
    always_comb begin
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        halted         = 1'b0;
        fault          = 1'b0;
        case (state_r)
            S_REQ:   imem_req_valid = 1'b1;
            S_VALID: inst_valid     = 1'b1;
            S_HALT:  halted         = 1'b1;
            S_FAULT: fault          = 1'b1;
            default: imem_req_valid = 1'b0;
        endcase
    end

    // Data outputs come straight from registers.
    always_comb begin
        imem_addr   = pc_r;
        pc          = pc_r;
        inst        = inst_r;
        fetch_cnt   = fetch_cnt_r;
        fault_cause = fault_cause_r;
    end

endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060096_ifu -- self-checking bench for the fetch unit.
// A transaction-level model tracks the expected PC, hand-off count and the
// word memory returned; a memory/downstream driver applies randomized stalls.
// ----------------------------------------------------------------------------
module tb_ysyx_23060096_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        halt;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fetch_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state
    logic [31:0] model_pc;
    logic [31:0] model_cnt;
    int          req_cyc;
    int          prev_req_cyc;
    int          lat;

    ysyx_23060096_ifu #(.RESET_PC(RESET_PC)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .imem_rsp_err  (imem_rsp_err),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .pc            (pc),
        .npc           (npc),
        .halt          (halt),
        .halted        (halted),
        .fault         (fault),
        .fault_cause   (fault_cause),
        .fetch_cnt     (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        npc            = 32'h0;
        halt           = 1'b0;
    endtask

    // Reset with a stale response presented both in reset and in IDLE.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        #1;
        model_pc  = RESET_PC;
        model_cnt = 32'd0;
        check("rst_pc", pc, RESET_PC);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_cnt", fetch_cnt, 32'd0);
        check("rst_cause", {30'd0, fault_cause}, 32'd0);
        check("rst_flags", {28'd0, imem_req_valid, inst_valid, halted, fault}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // IDLE: nothing requested yet, stale response still high
        check("idle_req", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("first_req", {31'd0, imem_req_valid}, 32'd1);
        check("first_addr", imem_addr, RESET_PC);
    endtask

    // One complete fetch. Entered at a negedge in the REQ state.
    // rdly: cycles req_ready is low; vdly: cycles before the response;
    // hdly: cycles inst_ready is low.
    task automatic fetch_one(input int rdly, input int vdly, input logic [31:0] word,
                             input logic err, input int hdly,
                             input logic [31:0] next_pc, input logic hlt);
        int t_req;
        t_req = cyc;
        prev_req_cyc = req_cyc;
        req_cyc = cyc;
        for (int i = 0; i <= rdly; i++) begin
            check("req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("req_addr", imem_addr, model_pc);
            imem_req_ready = (i == rdly);
            @(negedge clk);
        end
        imem_req_ready = 1'b0;
        for (int i = 0; i <= vdly; i++) begin
            check("wait_flags", {30'd0, imem_req_valid, inst_valid}, 32'd0);
            imem_rsp_valid = (i == vdly);
            imem_rsp_data  = (i == vdly) ? word : $urandom;
            imem_rsp_err   = (i == vdly) ? err : 1'($urandom);
            @(negedge clk);
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        if (err) begin
            check("memerr_fault", {31'd0, fault}, 32'd1);
            check("memerr_cause", {30'd0, fault_cause}, 32'd1);
            return;
        end
        lat = cyc - t_req;
        for (int i = 0; i <= hdly; i++) begin
            check("inst_valid", {31'd0, inst_valid}, 32'd1);
            check("inst", inst, word);
            check("pc", pc, model_pc);
            check("hold_cnt", fetch_cnt, model_cnt);
            check("no_req", {31'd0, imem_req_valid}, 32'd0);
            inst_ready = (i == hdly);
            npc  = (i == hdly) ? next_pc : $urandom;
            halt = (i == hdly) ? hlt : 1'($urandom);
            imem_rsp_valid = 1'($urandom);  // ignored outside WAIT
            @(negedge clk);
        end
        inst_ready     = 1'b0;
        halt           = 1'b0;
        imem_rsp_valid = 1'b0;
        model_cnt = model_cnt + 32'd1;
        model_pc  = next_pc;
        check("cnt", fetch_cnt, model_cnt);
        check("pc_upd", pc, model_pc);
        if (hlt) begin
            check("halted", {31'd0, halted}, 32'd1);
            check("halt_nofault", {31'd0, fault}, 32'd0);
        end else if (next_pc[1:0] != 2'b00) begin
            check("align_fault", {31'd0, fault}, 32'd1);
            check("align_cause", {30'd0, fault_cause}, 32'd2);
        end else begin
            check("next_req", {31'd0, imem_req_valid}, 32'd1);
        end
    endtask

    // Terminal state must ignore every input until reset.
    task automatic check_terminal(input logic exp_halted, input logic exp_fault,
                                  input logic [1:0] exp_cause, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            imem_req_ready = 1'($urandom);
            imem_rsp_valid = 1'($urandom);
            imem_rsp_err   = 1'($urandom);
            imem_rsp_data  = $urandom;
            inst_ready     = 1'($urandom);
            npc            = $urandom;
            halt           = 1'($urandom);
            @(negedge clk);
            check("term_hs", {30'd0, imem_req_valid, inst_valid}, 32'd0);
            check("term_halted", {31'd0, halted}, {31'd0, exp_halted});
            check("term_fault", {31'd0, fault}, {31'd0, exp_fault});
            check("term_cause", {30'd0, fault_cause}, {30'd0, exp_cause});
            check("term_pc", pc, model_pc);
            check("term_cnt", fetch_cnt, model_cnt);
        end
        idle_inputs();
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] nxt;
        rst = 1'b1;
        idle_inputs();
        model_pc = RESET_PC;
        model_cnt = 32'd0;
        req_cyc = 0;
        prev_req_cyc = 0;
        lat = 0;

        // zero-wait stream: 3 cycles per instruction
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            fetch_one(0, 0, 32'h0000_0013, 1'b0, 0, model_pc + 32'd4, 1'b0);
            if (k > 0) check("spacing", 32'(req_cyc - prev_req_cyc), 32'd3);
        end
        check("cnt_after3", fetch_cnt, 32'd3);

        // req_ready low 4 cycles, response 2 cycles after accept, downstream stalls 5
        fetch_one(4, 1, 32'h1234_5678, 1'b0, 5, model_pc + 32'd4, 1'b0);
        check("stall_latency", 32'(lat), 32'd7);

        // randomized stream with jumps
        for (int k = 0; k < 40; k++) begin
            w = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                nxt = $urandom;
                nxt[1:0] = 2'b00;
            end else begin
                nxt = model_pc + 32'd4;
            end
            fetch_one($urandom_range(0, 3), $urandom_range(0, 3), w, 1'b0,
                      $urandom_range(0, 3), nxt, 1'b0);
        end

        // misaligned npc
        fetch_one(0, 0, 32'h0000_0093, 1'b0, 0, 32'h8000_0102, 1'b0);
        check("mis_pc", pc, 32'h8000_0102);
        check_terminal(1'b0, 1'b1, 2'd2, 6);

        // memory error
        apply_reset();
        fetch_one(0, 0, 32'h0000_0013, 1'b0, 0, model_pc + 32'd4, 1'b0);
        fetch_one(1, 2, 32'h0, 1'b1, 0, 32'h0, 1'b0);
        check_terminal(1'b0, 1'b1, 2'd1, 6);

        // halt beats misaligned npc
        apply_reset();
        fetch_one(2, 0, 32'h0010_0073, 1'b0, 1, 32'h8000_0003, 1'b1);
        check_terminal(1'b1, 1'b0, 2'd0, 6);

        // reset while a response is outstanding
        apply_reset();
        fetch_one(0, 0, 32'h0000_0013, 1'b0, 0, 32'h8000_0040, 1'b0);
        fetch_one(0, 0, 32'h0000_0113, 1'b0, 0, 32'h8000_0044, 1'b0);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        check("in_wait", {30'd0, imem_req_valid, inst_valid}, 32'd0);
        apply_reset();
        fetch_one(0, 1, 32'hCAFE_0013, 1'b0, 0, model_pc + 32'd4, 1'b0);
        check("post_rst_cnt", fetch_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
